calc_parent: RTL and testbench

- Top of the calculator input path: debounced-edge button inputs build an editable token buffer (`mem`, depth entries of width bits) with a cursor.
- On eval, a number builder scans the buffer and merges digit/'.' runs into packed numeric words.
- Operator, paren, constant and function tokens pass through as `memOut` entries of newWidth bits.
- Downstream evaluators consume `memOut` after `done`.

---
 rtl/calc_pkg.sv | 57 +++++
 rtl/calc_parent_num_builder.sv | 177 +++++++++++++++++
 rtl/calc_parent.sv | 166 ++++++++++++++++
 tb/tb_calc_parent.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator input path.
//   - token codes stored in the edit buffer (button index + 1, 0 = empty)
//   - bit positions inside a built output entry
//   - builder FSM states and editor action codes
package calc_pkg;

  localparam int MAX_DIGITS = 10;

  // Token codes
  localparam logic [7:0] TOK_EMPTY = 8'd0;
  localparam logic [7:0] TOK_DIG0  = 8'd1;
  localparam logic [7:0] TOK_DIG9  = 8'd10;
  localparam logic [7:0] TOK_ADD   = 8'd11;
  localparam logic [7:0] TOK_SUB   = 8'd12;
  localparam logic [7:0] TOK_MUL   = 8'd13;
  localparam logic [7:0] TOK_DIV   = 8'd14;
  localparam logic [7:0] TOK_LPAR  = 8'd15;
  localparam logic [7:0] TOK_RPAR  = 8'd16;
  localparam logic [7:0] TOK_DOT   = 8'd17;
  localparam logic [7:0] TOK_POW   = 8'd18;
  localparam logic [7:0] TOK_PI    = 8'd19;
  localparam logic [7:0] TOK_E     = 8'd20;
  localparam logic [7:0] TOK_SQRT  = 8'd21;
  localparam logic [7:0] TOK_LN    = 8'd22;
  localparam logic [7:0] TOK_LOG   = 8'd23;
  localparam logic [7:0] TOK_SIN   = 8'd24;
  localparam logic [7:0] TOK_COS   = 8'd25;
  localparam logic [7:0] TOK_TAN   = 8'd26;

  // Output entry layout
  localparam int ENTRY_NUM_BIT = 41;
  localparam int EXP_MSB       = 40;
  localparam int EXP_LSB       = 36;
  localparam int MANT_MSB      = 35;
  localparam int TOKEN_MSB     = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_EMIT,
    ST_DONE
  } build_state_e;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_EVAL,
    ACT_DEL,
    ACT_LEFT,
    ACT_RIGHT,
    ACT_INS
  } edit_act_e;

  function automatic logic is_digit_tok(input logic [7:0] tok);
    return (tok >= TOK_DIG0) && (tok <= TOK_DIG9);
  endfunction

endpackage

// File: rtl/calc_parent_num_builder.sv
// num_builder: scans the token buffer once per eval and packs digit/'.' runs
// into numeric entries; every other token is copied through unchanged.
// Ports:
//   clock, reset      - clock and synchronous active-high reset
//   start_i           - accepted eval: clear outputs and begin scanning
//   clear_i           - accepted edit: drop done, return to idle
//   mem_bus_i         - flattened token buffer
//   count_i           - number of valid tokens
//   mem_out_bus_o     - flattened built entries
//   out_count_o       - number of valid built entries
//   done_o            - build complete
//   busy_o            - scan in progress (edits/eval must be ignored)
module num_builder
  import calc_pkg::*;
#(
  parameter int depth    = 20,
  parameter int width    = 8,
  parameter int newWidth = 42
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start_i,
  input  logic                      clear_i,
  input  logic [depth*width-1:0]    mem_bus_i,
  input  logic [4:0]                count_i,
  output logic [depth*newWidth-1:0] mem_out_bus_o,
  output logic [4:0]                out_count_o,
  output logic                      done_o,
  output logic                      busy_o
);

  build_state_e        state_q;
  logic [4:0]          idx_q;
  logic [4:0]          out_cnt_q;
  logic [35:0]         mant_q;
  logic [4:0]          exp_q;
  logic [3:0]          ndig_q;
  logic                run_q;
  logic                frac_q;
  logic                done_q;
  logic [newWidth-1:0] memOut [depth];

  logic [width-1:0]    tok_s;
  logic [7:0]          tok8_s;
  logic                is_digit_s;
  logic                is_dot_s;
  logic                at_end_s;
  logic                wr_ok_s;
  logic [35:0]         digit_s;
  logic [35:0]         mant_next_s;
  logic [newWidth-1:0] num_entry_s;
  logic [newWidth-1:0] tok_entry_s;

  // Select the token under the scan index (empty past the last entry).
  always_comb begin
    tok_s = '0;
    for (int i = 0; i < depth; i++) begin
      tok_s = (idx_q == 5'(i)) ? mem_bus_i[i*width +: width] : tok_s;
    end
  end

  assign tok8_s      = 8'(tok_s);
  assign is_digit_s  = is_digit_tok(tok8_s);
  assign is_dot_s    = (tok8_s == TOK_DOT);
  assign at_end_s    = (idx_q >= count_i);
  assign wr_ok_s     = (out_cnt_q < 5'(depth));
  assign digit_s     = 36'(tok8_s - TOK_DIG0);
  assign mant_next_s = (mant_q * 36'd10) + digit_s;

  // Assemble the two entry formats from the current run / token.
  always_comb begin
    num_entry_s                  = '0;
    num_entry_s[ENTRY_NUM_BIT]   = 1'b1;
    num_entry_s[EXP_MSB:EXP_LSB] = exp_q;
    num_entry_s[MANT_MSB:0]      = mant_q;
    tok_entry_s                  = '0;
    tok_entry_s[TOKEN_MSB:0]     = tok8_s;
  end

  // Build FSM: one token per SCAN clock, one extra EMIT clock per number.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= 5'd0;
      out_cnt_q <= 5'd0;
      mant_q    <= 36'd0;
      exp_q     <= 5'd0;
      ndig_q    <= 4'd0;
      run_q     <= 1'b0;
      frac_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < depth; i++) memOut[i] <= '0;
    end else if (start_i) begin
      state_q   <= ST_SCAN;
      idx_q     <= 5'd0;
      out_cnt_q <= 5'd0;
      mant_q    <= 36'd0;
      exp_q     <= 5'd0;
      ndig_q    <= 4'd0;
      run_q     <= 1'b0;
      frac_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < depth; i++) memOut[i] <= '0;
    end else if (clear_i) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_SCAN: begin
          if (at_end_s) begin
            // Flush an open run first; EMIT finishes the build itself.
            if (run_q) begin
              state_q <= ST_EMIT;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end else if (is_digit_s) begin
            if (!run_q) begin
              run_q  <= 1'b1;
              frac_q <= 1'b0;
              mant_q <= digit_s;
              exp_q  <= 5'd0;
              ndig_q <= 4'd1;
            end else if (ndig_q < 4'(MAX_DIGITS)) begin
              mant_q <= mant_next_s;
              ndig_q <= ndig_q + 4'd1;
              if (frac_q) exp_q <= exp_q + 5'd1;
            end
            idx_q <= idx_q + 5'd1;
          end else if (is_dot_s) begin
            // A leading '.' opens a run with mantissa 0; repeats are no-ops.
            if (!run_q) begin
              run_q  <= 1'b1;
              mant_q <= 36'd0;
              exp_q  <= 5'd0;
              ndig_q <= 4'd0;
            end
            frac_q <= 1'b1;
            idx_q  <= idx_q + 5'd1;
          end else if (run_q) begin
            // Number goes out first; this token is revisited after EMIT.
            state_q <= ST_EMIT;
          end else begin
            if (wr_ok_s) memOut[out_cnt_q] <= tok_entry_s;
            out_cnt_q <= out_cnt_q + 5'd1;
            idx_q     <= idx_q + 5'd1;
          end
        end
        ST_EMIT: begin
          if (wr_ok_s) memOut[out_cnt_q] <= num_entry_s;
          out_cnt_q <= out_cnt_q + 5'd1;
          run_q     <= 1'b0;
          frac_q    <= 1'b0;
          if (at_end_s) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_SCAN;
          end
        end
        ST_IDLE: state_q <= ST_IDLE;
        ST_DONE: state_q <= ST_DONE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < depth; g++) begin : g_out
    assign mem_out_bus_o[g*newWidth +: newWidth] = memOut[g];
  end

  assign out_count_o = out_cnt_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q == ST_SCAN) || (state_q == ST_EMIT);

endmodule

// File: rtl/calc_parent.sv
// calc_parent: calculator input path. Edge-detects the buttons, edits the
// token buffer around a cursor and hands the buffer to num_builder on eval.
// Ports:
//   clock, reset                 - clock and synchronous active-high reset
//   b                            - one-hot token buttons (levels)
//   del, ptrLeft, ptrRight, eval - control buttons (levels)
//   memBus                       - token buffer, entry i at [i*width +: width]
//   memOutBus                    - built entries, same packing
//   count, cursor, outCount      - buffer fill, insert position, built entries
//   done                         - build complete
module calc_parent
  import calc_pkg::*;
#(
  parameter int buttons  = 26,
  parameter int depth    = 20,
  parameter int width    = 8,
  parameter int newWidth = 42
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [buttons-1:0]        b,
  input  logic                      del,
  input  logic                      ptrLeft,
  input  logic                      ptrRight,
  input  logic                      eval,
  output logic [depth*width-1:0]    memBus,
  output logic [depth*newWidth-1:0] memOutBus,
  output logic [4:0]                count,
  output logic [4:0]                cursor,
  output logic [4:0]                outCount,
  output logic                      done
);

  logic [buttons-1:0] b_prev_q;
  logic               del_prev_q;
  logic               left_prev_q;
  logic               right_prev_q;
  logic               eval_prev_q;
  logic [width-1:0]   mem [depth];
  logic [4:0]         count_q;
  logic [4:0]         cursor_q;

  logic [buttons-1:0] b_rise_s;
  logic [4:0]         btn_idx_s;
  logic [width-1:0]   code_s;
  logic               busy_s;
  logic               start_s;
  logic               edit_s;
  edit_act_e          action_s;

  assign b_rise_s = b & ~b_prev_q;

  // Lowest-index rising button wins.
  always_comb begin
    btn_idx_s = 5'd0;
    for (int i = buttons - 1; i >= 0; i--) begin
      btn_idx_s = b_rise_s[i] ? 5'(i) : btn_idx_s;
    end
  end

  assign code_s = width'(btn_idx_s + 5'd1);

  // One action per cycle by fixed priority; nothing is accepted mid-build.
  always_comb begin
    action_s = ACT_NONE;
    if (busy_s) begin
      action_s = ACT_NONE;
    end else if (eval && !eval_prev_q) begin
      action_s = ACT_EVAL;
    end else if (del && !del_prev_q) begin
      action_s = ACT_DEL;
    end else if (ptrLeft && !left_prev_q) begin
      action_s = ACT_LEFT;
    end else if (ptrRight && !right_prev_q) begin
      action_s = ACT_RIGHT;
    end else if (|b_rise_s) begin
      action_s = ACT_INS;
    end else begin
      action_s = ACT_NONE;
    end
  end

  assign start_s = (action_s == ACT_EVAL);
  assign edit_s  = (action_s != ACT_NONE) && (action_s != ACT_EVAL);

  // Previous-level registers for rising-edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      b_prev_q     <= '0;
      del_prev_q   <= 1'b0;
      left_prev_q  <= 1'b0;
      right_prev_q <= 1'b0;
      eval_prev_q  <= 1'b0;
    end else begin
      b_prev_q     <= b;
      del_prev_q   <= del;
      left_prev_q  <= ptrLeft;
      right_prev_q <= ptrRight;
      eval_prev_q  <= eval;
    end
  end

  // Buffer editor: insert/delete shift the tail, cursor moves saturate.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= 5'd0;
      cursor_q <= 5'd0;
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    end else begin
      case (action_s)
        ACT_INS: begin
          if (count_q != 5'(depth)) begin
            for (int i = 1; i < depth; i++) begin
              if ((5'(i) > cursor_q) && (5'(i) <= count_q)) mem[i] <= mem[i-1];
            end
            mem[cursor_q] <= code_s;
            count_q       <= count_q + 5'd1;
            cursor_q      <= cursor_q + 5'd1;
          end
        end
        ACT_DEL: begin
          if (cursor_q != 5'd0) begin
            for (int i = 0; i < depth - 1; i++) begin
              if ((5'(i) >= cursor_q - 5'd1) && (5'(i) < count_q - 5'd1)) mem[i] <= mem[i+1];
            end
            mem[count_q - 5'd1] <= '0;
            count_q  <= count_q - 5'd1;
            cursor_q <= cursor_q - 5'd1;
          end
        end
        ACT_LEFT: begin
          if (cursor_q != 5'd0) cursor_q <= cursor_q - 5'd1;
        end
        ACT_RIGHT: begin
          if (cursor_q != count_q) cursor_q <= cursor_q + 5'd1;
        end
        default: cursor_q <= cursor_q;
      endcase
    end
  end

  for (genvar g = 0; g < depth; g++) begin : g_mem
    assign memBus[g*width +: width] = mem[g];
  end

  assign count  = count_q;
  assign cursor = cursor_q;

  num_builder #(
    .depth    (depth),
    .width    (width),
    .newWidth (newWidth)
  ) u_builder (
    .clock         (clock),
    .reset         (reset),
    .start_i       (start_s),
    .clear_i       (edit_s),
    .mem_bus_i     (memBus),
    .count_i       (count_q),
    .mem_out_bus_o (memOutBus),
    .out_count_o   (outCount),
    .done_o        (done),
    .busy_o        (busy_s)
  );

endmodule

// File: tb/tb_calc_parent.sv
module tb_calc_parent;

  localparam int DEPTH = 20;
  localparam int NW    = 42;

  logic         clock = 1'b0;
  logic         reset;
  logic [25:0]  b;
  logic         del, ptrLeft, ptrRight, eval;
  logic [159:0] memBus;
  logic [839:0] memOutBus;
  logic [4:0]   count, cursor, outCount;
  logic         done;

  int errors = 0;
  int checks = 0;

  // Reference: token list and cursor
  int mq[$];
  int mcur = 0;

  calc_parent dut (
    .clock(clock), .reset(reset), .b(b), .del(del), .ptrLeft(ptrLeft),
    .ptrRight(ptrRight), .eval(eval), .memBus(memBus), .memOutBus(memOutBus),
    .count(count), .cursor(cursor), .outCount(outCount), .done(done)
  );

  always #5 clock = ~clock;

  function automatic logic [159:0] model_bus();
    logic [159:0] v = '0;
    for (int i = 0; i < mq.size(); i++) v[i*8 +: 8] = 8'(mq[i]);
    return v;
  endfunction

  // Group each digit/'.' run, keep the first 10 digits, exponent = digits kept after the first '.'.
  task automatic model_build(output logic [839:0] ob, output int oc);
    int digs[$];
    int dotpos = -1;
    bit inrun = 0;
    longint mant;
    logic [41:0] e;
    ob = '0;
    oc = 0;
    for (int i = 0; i <= mq.size(); i++) begin
      int t = (i < mq.size()) ? mq[i] : 0;
      bit numtok = (i < mq.size()) && ((t >= 1 && t <= 10) || t == 17);
      if (numtok) begin
        inrun = 1;
        if (t == 17) begin
          if (dotpos < 0) dotpos = digs.size();
        end else if (digs.size() < 10) begin
          digs.push_back(t - 1);
        end
      end else begin
        if (inrun) begin
          mant = 0;
          foreach (digs[j]) mant = mant * 10 + digs[j];
          e = '0;
          e[41] = 1'b1;
          e[40:36] = (dotpos < 0) ? 5'd0 : 5'(digs.size() - dotpos);
          e[35:0] = 36'(mant);
          ob[oc*NW +: NW] = e;
          oc++;
          digs.delete();
          dotpos = -1;
          inrun = 0;
        end
        if (i < mq.size()) begin
          e = '0;
          e[7:0] = 8'(t);
          ob[oc*NW +: NW] = e;
          oc++;
        end
      end
    end
  endtask

  function automatic logic [41:0] out_entry(input int k);
    return memOutBus[k*NW +: NW];
  endfunction

  task automatic do_reset();
    b = '0; del = 0; ptrLeft = 0; ptrRight = 0; eval = 0;
    reset = 1;
    @(negedge clock);
    @(negedge clock);
    reset = 0;
    mq.delete();
    mcur = 0;
  endtask

  task automatic press_btn(input int idx);
    b = 26'd1 << idx;
    @(negedge clock);
    b = '0;
    @(negedge clock);
    if (mq.size() < DEPTH) begin
      mq.insert(mcur, idx + 1);
      mcur++;
    end
  endtask

  // 0 = del, 1 = ptrLeft, 2 = ptrRight
  task automatic press_ctl(input int which);
    case (which)
      0: del = 1;
      1: ptrLeft = 1;
      default: ptrRight = 1;
    endcase
    @(negedge clock);
    del = 0; ptrLeft = 0; ptrRight = 0;
    @(negedge clock);
    case (which)
      0: if (mcur > 0) begin mq.delete(mcur - 1); mcur--; end
      1: if (mcur > 0) mcur--;
      default: if (mcur < mq.size()) mcur++;
    endcase
  endtask

  // Returns clocks from the eval edge until done is seen (capped at 60).
  task automatic run_eval(output int cyc);
    eval = 1;
    @(negedge clock);
    eval = 0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (memBus !== '0 || memOutBus !== '0) begin
      errors++; $display("FAIL reset_arrays: memBus=%0h memOutBus=%0h expected 0", memBus, memOutBus);
    end
    checks++;
    if (count !== 5'd0 || cursor !== 5'd0 || outCount !== 5'd0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_regs: count=%0d cursor=%0d outCount=%0d done=%0b expected all 0", count, cursor, outCount, done);
    end
  endtask

  task automatic test_hold();
    do_reset();
    b = 26'd1 << 8;
    repeat (5) @(negedge clock);
    b = '0;
    @(negedge clock);
    checks++;
    if (memBus[7:0] !== 8'd9 || memBus[15:8] !== 8'd0 || count !== 5'd1 || cursor !== 5'd1) begin
      errors++; $display("FAIL hold_once: mem0=%0d mem1=%0d count=%0d cursor=%0d expected 9 0 1 1", memBus[7:0], memBus[15:8], count, cursor);
    end
  endtask

  task automatic test_edit();
    do_reset();
    press_btn(1); press_btn(2); press_btn(3);
    press_ctl(1); press_ctl(1);
    press_btn(10);
    checks++;
    if (memBus[31:0] !== {8'd4, 8'd3, 8'd11, 8'd2} || cursor !== 5'd2) begin
      errors++; $display("FAIL edit_insert: mem=%0h cursor=%0d expected 04030b02 2", memBus[31:0], cursor);
    end
    press_ctl(0);
    checks++;
    if (memBus[31:0] !== {8'd0, 8'd4, 8'd3, 8'd2} || cursor !== 5'd1 || count !== 5'd3) begin
      errors++; $display("FAIL edit_delete: mem=%0h cursor=%0d count=%0d expected 00040302 1 3", memBus[31:0], cursor, count);
    end
    // del and a button in the same cycle: only the delete happens
    del = 1; b = 26'd1 << 5;
    @(negedge clock);
    del = 0; b = '0;
    @(negedge clock);
    mq.delete(0); mcur = 0;
    checks++;
    if (memBus !== model_bus() || count !== 5'd2 || cursor !== 5'd0) begin
      errors++; $display("FAIL edit_priority: mem=%0h count=%0d cursor=%0d expected %0h 2 0", memBus, count, cursor, model_bus());
    end
    // cursor 0: delete ignored
    press_ctl(0);
    checks++;
    if (memBus !== model_bus() || count !== 5'd2) begin
      errors++; $display("FAIL edit_del_at_0: mem=%0h count=%0d expected %0h 2", memBus, count, model_bus());
    end
  endtask

  task automatic test_expression();
    int seq[19] = '{14, 8, 3, 16, 2, 3, 4, 1, 15, 12, 23, 14, 4, 16, 3, 2, 12, 18, 15};
    int cyc;
    int oc;
    logic [839:0] ob;
    logic [41:0] e1, e6;
    do_reset();
    foreach (seq[i]) press_btn(seq[i]);
    run_eval(cyc);
    model_build(ob, oc);
    e1 = out_entry(1);
    e6 = out_entry(6);
    checks++;
    if (done !== 1'b1 || outCount !== 5'd10 || cyc > 40) begin
      errors++; $display("FAIL expr_done: done=%0b outCount=%0d clocks=%0d expected 1 10 <=40", done, outCount, cyc);
    end
    checks++;
    if (e1[41] !== 1'b1 || e1[40:36] !== 5'd4 || e1[35:0] !== 36'd832341) begin
      errors++; $display("FAIL expr_num1: flag=%0b exp=%0d mant=%0d expected 1 4 832341", e1[41], e1[40:36], e1[35:0]);
    end
    checks++;
    if (e6[41] !== 1'b1 || e6[40:36] !== 5'd2 || e6[35:0] !== 36'd432) begin
      errors++; $display("FAIL expr_num6: flag=%0b exp=%0d mant=%0d expected 1 2 432", e6[41], e6[40:36], e6[35:0]);
    end
    checks++;
    if (memOutBus[4*NW +: 8] !== 8'd24 || memOutBus[8*NW +: 8] !== 8'd19 || memOutBus[0 +: 8] !== 8'd15) begin
      errors++; $display("FAIL expr_tokens: e4=%0d e8=%0d e0=%0d expected 24 19 15", memOutBus[4*NW +: 8], memOutBus[8*NW +: 8], memOutBus[0 +: 8]);
    end
    checks++;
    if (memOutBus !== ob || int'(outCount) != oc) begin
      errors++; $display("FAIL expr_model: memOutBus=%0h expected %0h", memOutBus, ob);
    end
    press_ctl(1);
    checks++;
    if (done !== 1'b0 || cursor !== 5'd18) begin
      errors++; $display("FAIL expr_edit_clears_done: done=%0b cursor=%0d expected 0 18", done, cursor);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) press_btn(int'($urandom_range(0, 25)));
    press_btn(7);
    checks++;
    if (count !== 5'd20 || memBus !== model_bus()) begin
      errors++; $display("FAIL full_ignore: count=%0d mem=%0h expected 20 %0h", count, memBus, model_bus());
    end
    press_ctl(2);
    checks++;
    if (cursor !== 5'd20) begin
      errors++; $display("FAIL full_right_sat: cursor=%0d expected 20", cursor);
    end
  endtask

  task automatic test_dot_run();
    int cyc;
    logic [41:0] e0;
    do_reset();
    press_btn(1); press_btn(16); press_btn(2); press_btn(16); press_btn(5);
    run_eval(cyc);
    e0 = out_entry(0);
    checks++;
    if (done !== 1'b1 || outCount !== 5'd1 || e0 !== {1'b1, 5'd2, 36'd125}) begin
      errors++; $display("FAIL dot_run: done=%0b outCount=%0d entry=%0h expected 1 1 %0h", done, outCount, e0, {1'b1, 5'd2, 36'd125});
    end
    do_reset();
    run_eval(cyc);
    checks++;
    if (done !== 1'b1 || outCount !== 5'd0 || cyc > 2) begin
      errors++; $display("FAIL empty_eval: done=%0b outCount=%0d clocks=%0d expected 1 0 <=2", done, outCount, cyc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 10; i++) press_btn(i);
    eval = 1;
    @(negedge clock);
    eval = 0;
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    checks++;
    if (memBus !== '0 || memOutBus !== '0 || count !== 5'd0 || cursor !== 5'd0 || outCount !== 5'd0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_mid: count=%0d cursor=%0d outCount=%0d done=%0b expected all 0", count, cursor, outCount, done);
    end
    reset = 0;
    mq.delete(); mcur = 0;
    repeat (25) @(negedge clock);
    checks++;
    if (done !== 1'b0 || outCount !== 5'd0) begin
      errors++; $display("FAIL reset_mid_after: done=%0b outCount=%0d expected 0 0", done, outCount);
    end
  endtask

  task automatic test_random();
    int cyc, oc, r;
    logic [839:0] ob;
    for (int round = 0; round < 4; round++) begin
      do_reset();
      for (int op = 0; op < 30; op++) begin
        r = int'($urandom_range(0, 9));
        if (r < 3) press_ctl(r);
        else if ($urandom_range(0, 1) == 1) press_btn((r == 3) ? 16 : int'($urandom_range(0, 9)));
        else press_btn(int'($urandom_range(0, 25)));
        checks++;
        if (memBus !== model_bus() || int'(count) != mq.size() || int'(cursor) != mcur) begin
          errors++; $display("FAIL rand_edit r%0d op%0d: mem=%0h count=%0d cursor=%0d expected %0h %0d %0d", round, op, memBus, count, cursor, model_bus(), mq.size(), mcur);
        end
      end
      run_eval(cyc);
      model_build(ob, oc);
      checks++;
      if (done !== 1'b1 || memOutBus !== ob || int'(outCount) != oc || cyc > 2 * mq.size() + 2) begin
        errors++; $display("FAIL rand_build r%0d: done=%0b outCount=%0d clocks=%0d expected 1 %0d <=%0d", round, done, outCount, cyc, oc, 2 * mq.size() + 2);
      end
    end
  endtask

  initial begin
    b = '0; del = 0; ptrLeft = 0; ptrRight = 0; eval = 0; reset = 1;
    test_reset();
    test_hold();
    test_edit();
    test_expression();
    test_full();
    test_dot_run();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
